// File: rtl/costas_lock_ctrl.sv
// Lock sequencer for a Costas carrier-recovery loop: measures per-window |Q|/|I|
// quality, steps CLEAR -> ACQUIRE -> TRACK -> LOCKED and gates the downstream stream.
module costas_lock_ctrl #(
   parameter int unsigned WINDOW_LOG2     = 8,
   parameter int unsigned Q_RATIO_SHIFT   = 3,
   parameter int unsigned LOCK_COUNT      = 4,
   parameter int unsigned UNLOCK_COUNT    = 2,
   parameter int unsigned TIMEOUT_WINDOWS = 64,
   parameter int unsigned CLEAR_CYCLES    = 4
) (
   input  logic        s00_axis_aclk,
   input  logic        s00_axis_areset,
   input  logic        enable,
   input  logic [31:0] s00_axis_tdata,
   input  logic        s00_axis_tvalid,
   input  logic        s00_axis_tlast,
   output logic        s00_axis_tready,
   output logic [31:0] m00_axis_tdata,
   output logic        m00_axis_tvalid,
   output logic        m00_axis_tlast,
   input  logic        m00_axis_tready,
   output logic [1:0]  gain_sel,
   output logic        loop_clear,
   output logic        locked,
   output logic [2:0]  state_o,
   output logic [7:0]  retry_count
);
   localparam int unsigned ACC_W = 15 + WINDOW_LOG2;
   localparam int unsigned CMP_W = ACC_W + Q_RATIO_SHIFT;
   localparam int unsigned WIN_W = $clog2(TIMEOUT_WINDOWS + 1);
   localparam int unsigned LCK_W = $clog2(LOCK_COUNT + 1);
   localparam int unsigned UNL_W = $clog2(UNLOCK_COUNT + 1);
   localparam int unsigned CLR_W = $clog2(CLEAR_CYCLES + 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_ACQUIRE = 3'd2,
      ST_TRACK   = 3'd3,
      ST_LOCKED  = 3'd4
   } state_t;

   state_t                 state, state_nx;
   logic [WINDOW_LOG2-1:0] idx, idx_nx;
   logic [ACC_W-1:0]       sum_i, sum_i_nx, sum_q, sum_q_nx, sum_i_add, sum_q_add;
   logic [WIN_W-1:0]       win_cnt, win_nx, win_inc;
   logic [LCK_W-1:0]       good_cnt, good_nx, good_inc;
   logic [UNL_W-1:0]       bad_cnt, bad_nx, bad_inc;
   logic [CLR_W-1:0]       clr_cnt, clr_nx;
   logic [7:0]             retry_nx;
   logic [1:0]             gain_nx;
   logic                   active, accept, win_done, good, timeout;

   // Saturating magnitude so that -32768 maps to 32767 and fits in 15 bits.
   function automatic logic [14:0] sat_abs(input logic [15:0] x);
      logic [15:0] n;
      n = -x;
      if (!x[15])           return x[14:0];
      else if (x == 16'h8000) return 15'h7fff;
      else                  return n[14:0];
   endfunction

   assign active          = (state == ST_ACQUIRE) || (state == ST_TRACK) || (state == ST_LOCKED);
   assign s00_axis_tready = (state == ST_LOCKED) ? m00_axis_tready : 1'b1;
   assign accept          = s00_axis_tvalid && s00_axis_tready;
   assign m00_axis_tdata  = s00_axis_tdata;
   assign m00_axis_tlast  = s00_axis_tlast;
   assign m00_axis_tvalid = s00_axis_tvalid && (state == ST_LOCKED);
   assign state_o         = state;

   assign sum_i_add = sum_i + ACC_W'(sat_abs(s00_axis_tdata[15:0]));
   assign sum_q_add = sum_q + ACC_W'(sat_abs(s00_axis_tdata[31:16]));
   assign win_done  = active && accept && (idx == '1);
   assign good      = (CMP_W'(sum_q_add) << Q_RATIO_SHIFT) < CMP_W'(sum_i_add);
   assign win_inc   = WIN_W'(win_cnt + 1'b1);
   assign good_inc  = LCK_W'(good_cnt + 1'b1);
   assign bad_inc   = UNL_W'(bad_cnt + 1'b1);
   assign timeout   = (win_inc == WIN_W'(TIMEOUT_WINDOWS));

   // Next-state, window accumulation and counter updates.
   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      sum_i_nx = sum_i;
      sum_q_nx = sum_q;
      win_nx   = win_cnt;
      good_nx  = good_cnt;
      bad_nx   = bad_cnt;
      clr_nx   = '0;
      retry_nx = retry_count;
      gain_nx  = 2'd2;

      if (active && accept) begin
         if (win_done) begin
            idx_nx   = '0;
            sum_i_nx = '0;
            sum_q_nx = '0;
         end else begin
            idx_nx   = WINDOW_LOG2'(idx + 1'b1);
            sum_i_nx = sum_i_add;
            sum_q_nx = sum_q_add;
         end
      end

      case (state)
         ST_IDLE: if (enable) state_nx = ST_CLEAR;
         ST_CLEAR: begin
            clr_nx  = CLR_W'(clr_cnt + 1'b1);
            win_nx  = '0;
            good_nx = '0;
            bad_nx  = '0;
            if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) begin
               clr_nx   = '0;
               state_nx = ST_ACQUIRE;
            end
         end
         ST_ACQUIRE, ST_TRACK: begin
            if (win_done) begin
               win_nx = win_inc;
               if (timeout) begin
                  state_nx = ST_CLEAR;
                  retry_nx = (retry_count == 8'hff) ? retry_count : 8'(retry_count + 1'b1);
               end else if (!good) begin
                  state_nx = ST_ACQUIRE;
                  good_nx  = '0;
               end else if (((state == ST_ACQUIRE) ? LCK_W'(1) : good_inc) >= LCK_W'(LOCK_COUNT)) begin
                  state_nx = ST_LOCKED;
                  good_nx  = '0;
                  bad_nx   = '0;
               end else begin
                  state_nx = ST_TRACK;
                  good_nx  = (state == ST_ACQUIRE) ? LCK_W'(1) : good_inc;
               end
            end
         end
         ST_LOCKED: begin
            if (win_done) begin
               if (good) begin
                  bad_nx = '0;
               end else if (bad_inc == UNL_W'(UNLOCK_COUNT)) begin
                  state_nx = ST_ACQUIRE;
                  bad_nx   = '0;
                  good_nx  = '0;
                  win_nx   = '0;
               end else begin
                  bad_nx = bad_inc;
               end
            end
         end
         default: state_nx = ST_IDLE;
      endcase

      // Disable abandons any partial window; retry history survives.
      if (!enable) begin
         state_nx = ST_IDLE;
         idx_nx   = '0;
         sum_i_nx = '0;
         sum_q_nx = '0;
         win_nx   = '0;
         good_nx  = '0;
         bad_nx   = '0;
         clr_nx   = '0;
      end

      case (state_nx)
         ST_TRACK:  gain_nx = 2'd1;
         ST_LOCKED: gain_nx = 2'd0;
         default:   gain_nx = 2'd2;
      endcase
   end

   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         state       <= ST_IDLE;
         idx         <= '0;
         sum_i       <= '0;
         sum_q       <= '0;
         win_cnt     <= '0;
         good_cnt    <= '0;
         bad_cnt     <= '0;
         clr_cnt     <= '0;
         retry_count <= '0;
         gain_sel    <= 2'd2;
         loop_clear  <= 1'b0;
         locked      <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         sum_i       <= sum_i_nx;
         sum_q       <= sum_q_nx;
         win_cnt     <= win_nx;
         good_cnt    <= good_nx;
         bad_cnt     <= bad_nx;
         clr_cnt     <= clr_nx;
         retry_count <= retry_nx;
         gain_sel    <= gain_nx;
         loop_clear  <= (state_nx == ST_CLEAR);
         locked      <= (state_nx == ST_LOCKED);
      end
   end
endmodule

// File: tb/tb_costas_lock_ctrl.sv
// Self-checking bench for costas_lock_ctrl: directed lock/unlock/timeout scenarios
// with a scoreboard of samples expected on the forwarded stream.
module tb_costas_lock_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [31:0] s_tdata;
   logic        s_tvalid, s_tlast, s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid, m_tlast, m_tready;
   logic [1:0]  gain_sel;
   logic        loop_clear, locked;
   logic [2:0]  state_o;
   logic [7:0]  retry_count;

   int checks = 0;
   int failures = 0;
   bit exp_locked = 0;
   logic [32:0] sb[$];

   always #5 clk = ~clk;

   costas_lock_ctrl #(
      .WINDOW_LOG2(4), .Q_RATIO_SHIFT(3), .LOCK_COUNT(2),
      .UNLOCK_COUNT(2), .TIMEOUT_WINDOWS(8), .CLEAR_CYCLES(4)
   ) dut (
      .s00_axis_aclk(clk), .s00_axis_areset(rst), .enable(enable),
      .s00_axis_tdata(s_tdata), .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
      .s00_axis_tready(s_tready),
      .m00_axis_tdata(m_tdata), .m00_axis_tvalid(m_tvalid), .m00_axis_tlast(m_tlast),
      .m00_axis_tready(m_tready),
      .gain_sel(gain_sel), .loop_clear(loop_clear), .locked(locked),
      .state_o(state_o), .retry_count(retry_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive one sample (called at a negedge) until accepted; returns at the next negedge.
   task automatic send(input logic [15:0] i, input logic [15:0] q, input logic last);
      bit acc = 0;
      logic [32:0] e;
      s_tdata = {q, i}; s_tvalid = 1'b1; s_tlast = last;
      if (exp_locked) sb.push_back({last, q, i});
      for (int k = 0; k < 50 && !acc; k++) begin
         #1;
         if (m_tvalid && m_tready) begin
            if (sb.size() == 0) chk("fwd_unexpected", 1, 0);
            else begin
               e = sb.pop_front();
               chk("fwd_data", {m_tlast, m_tdata}, e);
            end
         end
         acc = s_tready;
         @(negedge clk);
      end
      if (!acc) chk("accept_timeout", 0, 1);
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic send_n(input logic [15:0] i, input logic [15:0] q, input int n, input bit ends_window);
      for (int k = 0; k < n; k++) send(i, q, ends_window && (k == n - 1));
   endtask

   task automatic send_window(input logic [15:0] i, input logic [15:0] q);
      send_n(i, q, 16, 1'b1);
   endtask

   // Count loop_clear cycles until ACQUIRE is reached (bounded).
   task automatic clear_phase(output int n);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         if (loop_clear) n++;
         if (state_o == 3'd2) break;
         @(negedge clk);
      end
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
   endtask

   initial begin
      int n, stall_bad;
      rst = 1'b1; enable = 1'b0; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_state", state_o, 0);
      chk("rst_gain", gain_sel, 2);
      chk("rst_clear", loop_clear, 0);
      chk("rst_retry", retry_count, 0);
      chk("rst_tready", s_tready, 1);

      // Clean acquisition to lock, first locked sample forwarded
      enable = 1'b1;
      clear_phase(n);
      chk("clear_len", n, 4);
      chk("acq_state", state_o, 2);
      send_n(16'd1000, 16'd50, 15, 1'b0);
      chk("acq15_state", state_o, 2);
      chk("acq15_gain", gain_sel, 2);
      send(16'd1000, 16'd50, 1'b1);
      chk("trk_state", state_o, 3);
      chk("trk_gain", gain_sel, 1);
      send_window(16'd1000, 16'd50);
      chk("lock_state", state_o, 4);
      chk("lock_gain", gain_sel, 0);
      chk("lock_flag", locked, 1);
      exp_locked = 1;
      send(16'hfc18, 16'd50, 1'b1);
      send(16'd1000, 16'hffce, 1'b0);
      exp_locked = 0;

      // Asynchronous reset while locked
      s_tvalid = 1'b1; s_tdata = 32'h0032_03e8;
      rst = 1'b1;
      #1;
      chk("arst_state", state_o, 0);
      chk("arst_gain", gain_sel, 2);
      chk("arst_locked", locked, 0);
      chk("arst_mvalid", m_tvalid, 0);
      chk("arst_retry", retry_count, 0);
      s_tvalid = 1'b0;
      @(negedge clk); rst = 1'b0;
      chk("sb_after_lock", sb.size(), 0);

      // Ratio threshold at equality is bad, one below is good
      clear_phase(n);
      chk("clear_len2", n, 4);
      send_window(16'd1000, 16'd125);
      chk("thr_equal_bad", state_o, 2);
      send_window(16'd1000, 16'd124);
      chk("thr_below_good", state_o, 3);
      send_window(16'd1000, 16'd50);
      chk("relock_state", state_o, 4);

      // Unlock needs two consecutive bad windows
      exp_locked = 1;
      send_window(16'd1000, 16'd1000);
      chk("unl_bad1", state_o, 4);
      send_window(16'd1000, 16'd50);
      chk("unl_good", state_o, 4);
      send_window(16'd1000, 16'd1000);
      chk("unl_bad2", state_o, 4);
      send_window(16'd1000, 16'd1000);
      exp_locked = 0;
      chk("unl_state", state_o, 2);
      chk("unl_gain", gain_sel, 2);
      chk("unl_locked", locked, 0);
      send_window(16'h8000, 16'd0);
      chk("min_i_good", state_o, 3);

      // Timeout after 8 windows with no lock, then retry saturation
      pulse_reset();
      clear_phase(n);
      for (int w = 0; w < 7; w++) send_window(16'd0, 16'd1000);
      chk("to7_state", state_o, 2);
      send_window(16'd0, 16'd1000);
      chk("to_state", state_o, 1);
      chk("to_retry", retry_count, 1);
      clear_phase(n);
      chk("to_clear_len", n, 4);
      for (int r = 0; r < 255; r++) begin
         if (r > 0) clear_phase(n);
         for (int w = 0; w < 8; w++) send_window(16'd0, 16'd1000);
      end
      chk("retry_255", retry_count, 255);
      clear_phase(n);
      for (int w = 0; w < 8; w++) send_window(16'd0, 16'd1000);
      chk("retry_sat", retry_count, 255);

      // Downstream back-pressure freezes the window
      pulse_reset();
      clear_phase(n);
      send_window(16'd1000, 16'd50);
      send_window(16'd1000, 16'd50);
      chk("bp_lock", state_o, 4);
      exp_locked = 1;
      send_n(16'd1000, 16'd1000, 5, 1'b0);
      m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 32'h03e8_03e8;
      stall_bad = 0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (s_tready !== 1'b0) stall_bad++;
         @(negedge clk);
      end
      s_tvalid = 1'b0; m_tready = 1'b1;
      chk("bp_tready_low", stall_bad, 0);
      chk("bp_state", state_o, 4);
      send_n(16'd1000, 16'd1000, 11, 1'b1);
      chk("bp_win1", state_o, 4);
      send_n(16'd1000, 16'd1000, 15, 1'b0);
      chk("bp_win2_partial", state_o, 4);
      send(16'd1000, 16'd1000, 1'b1);
      exp_locked = 0;
      chk("bp_unlock", state_o, 2);

      // Disable mid-window, then a full fresh window is needed
      send_n(16'd1000, 16'd50, 5, 1'b0);
      enable = 1'b0;
      @(negedge clk);
      chk("dis_state", state_o, 0);
      enable = 1'b1;
      clear_phase(n);
      chk("reen_clear_len", n, 4);
      chk("reen_retry", retry_count, 0);
      send_n(16'd1000, 16'd50, 15, 1'b0);
      chk("reen15_state", state_o, 2);
      send(16'd1000, 16'd50, 1'b1);
      chk("reen16_state", state_o, 3);
      chk("sb_empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
